// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-bus controller: FSM state
// encodings and the unshifted access-size masks.
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        MB_IDLE = 2'd0,
        MB_REQ  = 2'd1,
        MB_WAIT = 2'd2,
        MB_DONE = 2'd3
    } mb_state_e;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    localparam int MEM_SEL_W = 4;

endpackage

// File: rtl/mem_bus_ctrl_lane_align.sv
// Combinational byte-lane alignment: shifts the size mask and store data into
// their lanes and flags misaligned accesses when MEM_ALIGN_CHECK_EN is defined.
module mem_lane_align
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [MEM_SEL_W-1:0] sel_i,
    input  logic [1:0]           sh_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [MEM_SEL_W-1:0] sel_o,
    output logic [DATA_W-1:0]    wdata_o,
    output logic                 misaligned_o
);

    // Lanes pushed past lane 3 simply fall off the top.
    assign sel_o   = sel_i << sh_i;
    assign wdata_o = wdata_i << {sh_i, 3'b000};

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned_o = ((sel_i == SEL_WORD) && (sh_i != 2'b00)) ||
                          ((sel_i == SEL_HALF) && sh_i[0]);
`else
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage controller turning one load/store into a req/addr_ok/data_ok bus
// transaction. Optional alignment checking is enabled by MEM_ALIGN_CHECK_EN.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall_i,
    input  logic              mem_read_flag_i,
    input  logic              mem_write_flag_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] write_data_i,
    output logic              ram_req_o,
    output logic              ram_wr_o,
    output logic [3:0]        ram_wstrb_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic              ram_addr_ok_i,
    input  logic              ram_data_ok_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [DATA_W-1:0] ram_read_data_o,
    output logic [3:0]        mem_sel_o,
    output logic              stall_request_o,
    output logic              adel_o,
    output logic              ades_o
);

    mb_state_e         state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              wr_q, wr_d;
    logic              load_q, load_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [3:0]        sel_shifted;
    logic [DATA_W-1:0] wdata_shifted;
    logic              misaligned;
    logic              access;
    logic              resp;
    logic              kill;
    logic              capture;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .sel_i        (mem_sel_i),
        .sh_i         (addr_i[1:0]),
        .wdata_i      (write_data_i),
        .sel_o        (sel_shifted),
        .wdata_o      (wdata_shifted),
        .misaligned_o (misaligned)
    );

    assign adel_o    = mem_read_flag_i & misaligned;
    assign ades_o    = mem_write_flag_i & misaligned;
    assign mem_sel_o = sel_shifted;
    assign access    = (mem_read_flag_i | mem_write_flag_i) & ~flush & ~(adel_o | ades_o);

    // A response this cycle: in WAIT, or in REQ when accepted and answered together.
    assign resp = ram_data_ok_i & ((state_q == MB_WAIT) ||
                                   ((state_q == MB_REQ) && ram_addr_ok_i));
    assign kill = cancel_q | flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MB_IDLE;
            cancel_q <= 1'b0;
            wr_q     <= 1'b0;
            load_q   <= 1'b0;
            wstrb_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            wr_q     <= wr_d;
            load_q   <= load_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        rdata_d  = rdata_q;
        capture  = 1'b0;

        case (state_q)
            MB_IDLE: begin
                if (access) begin
                    state_d = MB_REQ;
                    capture = 1'b1;
                end
            end
            MB_REQ: begin
                if (flush) cancel_d = 1'b1;
                if (ram_addr_ok_i) state_d = MB_WAIT;
            end
            MB_WAIT: begin
                if (flush) cancel_d = 1'b1;
            end
            MB_DONE: begin
                if (flush || !stall_i) state_d = MB_IDLE;
            end
            default: state_d = MB_IDLE;
        endcase

        // A cancelled response is dropped; a pending access issues straight away.
        if (resp) begin
            if (kill) begin
                cancel_d = 1'b0;
                if (access) begin
                    state_d = MB_REQ;
                    capture = 1'b1;
                end else begin
                    state_d = MB_IDLE;
                end
            end else begin
                if (load_q) rdata_d = ram_rdata_i;
                state_d = stall_i ? MB_DONE : MB_IDLE;
            end
        end
    end

    always_comb begin
        wr_d    = wr_q;
        load_d  = load_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (capture) begin
            wr_d    = mem_write_flag_i;
            load_d  = mem_read_flag_i & ~mem_write_flag_i;
            wstrb_d = sel_shifted;
            addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            wdata_d = wdata_shifted;
        end
    end

    // Read data bypasses the register on data_ok so MEMWB sees it that cycle.
    always_comb begin
        ram_req_o       = (state_q == MB_REQ);
        ram_wr_o        = wr_q;
        ram_wstrb_o     = wstrb_q;
        ram_addr_o      = addr_q;
        ram_wdata_o     = wdata_q;
        ram_read_data_o = (resp && !kill && load_q) ? ram_rdata_i : rdata_q;
        stall_request_o = 1'b0;
        case (state_q)
            MB_IDLE:         stall_request_o = access;
            MB_REQ, MB_WAIT: stall_request_o = cancel_q ? access : ~resp;
            default:         stall_request_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl; the alignment section follows
// MEM_ALIGN_CHECK_EN so the same bench covers both builds.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall_i;
    logic        mem_read_flag_i;
    logic        mem_write_flag_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic        ram_req_o;
    logic        ram_wr_o;
    logic [3:0]  ram_wstrb_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic        ram_addr_ok_i;
    logic        ram_data_ok_i;
    logic [31:0] ram_rdata_i;
    logic [31:0] ram_read_data_o;
    logic [3:0]  mem_sel_o;
    logic        stall_request_o;
    logic        adel_o;
    logic        ades_o;

    int testsRun;
    int testsFailed;

    mem_bus_ctrl #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .stall_i          (stall_i),
        .mem_read_flag_i  (mem_read_flag_i),
        .mem_write_flag_i (mem_write_flag_i),
        .mem_sel_i        (mem_sel_i),
        .addr_i           (addr_i),
        .write_data_i     (write_data_i),
        .ram_req_o        (ram_req_o),
        .ram_wr_o         (ram_wr_o),
        .ram_wstrb_o      (ram_wstrb_o),
        .ram_addr_o       (ram_addr_o),
        .ram_wdata_o      (ram_wdata_o),
        .ram_addr_ok_i    (ram_addr_ok_i),
        .ram_data_ok_i    (ram_data_ok_i),
        .ram_rdata_i      (ram_rdata_i),
        .ram_read_data_o  (ram_read_data_o),
        .mem_sel_o        (mem_sel_o),
        .stall_request_o  (stall_request_o),
        .adel_o           (adel_o),
        .ades_o           (ades_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] sel,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        mem_read_flag_i  = rd;
        mem_write_flag_i = wr;
        mem_sel_i        = sel;
        addr_i           = addr;
        write_data_i     = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] rdata);
        ram_addr_ok_i = aok;
        ram_data_ok_i = dok;
        ram_rdata_i   = rdata;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b0;
        flush       = 1'b0;
        stall_i     = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 32'h0);

        #2;
        checkOutput("rst_req",   {31'b0, ram_req_o}, 32'h0);
        checkOutput("rst_stall", {31'b0, stall_request_o}, 32'h0);
        checkOutput("rst_rdata", ram_read_data_o, 32'h0);
        checkOutput("rst_addr",  ram_addr_o, 32'h0);
        tick();
        rst = 1'b1;

        // Word load at 0x1000
        tick();
        applyStimulus(1'b1, 1'b0, 4'b1111, 32'h0000_1000, 32'h0);
        @(negedge clk);
        checkOutput("ld_idle_stall", {31'b0, stall_request_o}, 32'h1);
        checkOutput("ld_idle_req",   {31'b0, ram_req_o}, 32'h0);
        tick();
        bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("ld_req",       {31'b0, ram_req_o}, 32'h1);
        checkOutput("ld_addr",      ram_addr_o, 32'h0000_1000);
        checkOutput("ld_wstrb",     {28'b0, ram_wstrb_o}, 32'hF);
        checkOutput("ld_wr",        {31'b0, ram_wr_o}, 32'h0);
        checkOutput("ld_req_stall", {31'b0, stall_request_o}, 32'h1);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("ld_wait_req",   {31'b0, ram_req_o}, 32'h0);
        checkOutput("ld_wait_stall", {31'b0, stall_request_o}, 32'h1);
        tick();
        bus(1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("ld_data",       ram_read_data_o, 32'hDEAD_BEEF);
        checkOutput("ld_data_stall", {31'b0, stall_request_o}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("ld_hold", ram_read_data_o, 32'hDEAD_BEEF);
        checkOutput("ld_idle_after", {31'b0, ram_req_o}, 32'h0);

        // Byte store of 0xA5 at 0x2003, addr_ok and data_ok together
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0001, 32'h0000_2003, 32'h0000_00A5);
        @(negedge clk);
        checkOutput("st_memsel", {28'b0, mem_sel_o}, 32'h8);
        tick();
        bus(1'b1, 1'b1, 32'h5555_5555);
        @(negedge clk);
        checkOutput("st_req",   {31'b0, ram_req_o}, 32'h1);
        checkOutput("st_wr",    {31'b0, ram_wr_o}, 32'h1);
        checkOutput("st_wstrb", {28'b0, ram_wstrb_o}, 32'h8);
        checkOutput("st_wdata", ram_wdata_o, 32'hA500_0000);
        checkOutput("st_addr",  ram_addr_o, 32'h0000_2000);
        checkOutput("st_stall", {31'b0, stall_request_o}, 32'h0);
        checkOutput("st_rdata_kept", ram_read_data_o, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("st_after_req", {31'b0, ram_req_o}, 32'h0);

        // Load completing under external stall -> DONE holds data
        tick();
        applyStimulus(1'b1, 1'b0, 4'b1111, 32'h0000_3004, 32'h0);
        tick();
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b1, 32'h1234_5678);
        stall_i = 1'b1;
        @(negedge clk);
        checkOutput("dn_data", ram_read_data_o, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus(1'b0, 1'b0, 32'hFFFF_FFFF);
            @(negedge clk);
            checkOutput("dn_hold",  ram_read_data_o, 32'h1234_5678);
            checkOutput("dn_noreq", {31'b0, ram_req_o}, 32'h0);
            checkOutput("dn_stall", {31'b0, stall_request_o}, 32'h0);
        end
        tick();
        stall_i = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("dn_exit_req", {31'b0, ram_req_o}, 32'h0);

        // Flush in WAIT, then a new load pending while the old response drains
        tick();
        applyStimulus(1'b1, 1'b0, 4'b1111, 32'h0000_4000, 32'h0);
        tick();
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'b1111, 32'h0000_5008, 32'h0);
        @(negedge clk);
        checkOutput("fl_pending_stall", {31'b0, stall_request_o}, 32'h1);
        checkOutput("fl_pending_req",   {31'b0, ram_req_o}, 32'h0);
        tick();
        bus(1'b0, 1'b1, 32'hBAD0_BAD0);
        @(negedge clk);
        checkOutput("fl_discard", ram_read_data_o, 32'h1234_5678);
        checkOutput("fl_drain_stall", {31'b0, stall_request_o}, 32'h1);
        tick();
        bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("fl_new_req",  {31'b0, ram_req_o}, 32'h1);
        checkOutput("fl_new_addr", ram_addr_o, 32'h0000_5008);
        tick();
        bus(1'b0, 1'b1, 32'hCAFE_F00D);
        @(negedge clk);
        checkOutput("fl_new_data", ram_read_data_o, 32'hCAFE_F00D);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 32'h0);

        // Half store with addr_ok withheld for 5 cycles; inputs wander meanwhile
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0011, 32'h0000_6002, 32'h0000_1234);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b1111, 32'h0000_7778, 32'h9999_9999);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("wh_req",   {31'b0, ram_req_o}, 32'h1);
            checkOutput("wh_addr",  ram_addr_o, 32'h0000_6000);
            checkOutput("wh_wdata", ram_wdata_o, 32'h1234_0000);
            checkOutput("wh_wstrb", {28'b0, ram_wstrb_o}, 32'hC);
            tick();
        end
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("wh_done_stall", {31'b0, stall_request_o}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
        tick();
        applyStimulus(1'b1, 1'b0, 4'b1111, 32'h0000_1002, 32'h0);
        @(negedge clk);
        checkOutput("al_adel",  {31'b0, adel_o}, 32'h1);
        checkOutput("al_ades",  {31'b0, ades_o}, 32'h0);
        checkOutput("al_stall", {31'b0, stall_request_o}, 32'h0);
        tick();
        @(negedge clk);
        checkOutput("al_noreq", {31'b0, ram_req_o}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0011, 32'h0000_1001, 32'h0);
        @(negedge clk);
        checkOutput("al_ades_half", {31'b0, ades_o}, 32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
`else
        tick();
        applyStimulus(1'b0, 1'b1, 4'b1111, 32'h0000_1002, 32'hAABB_CCDD);
        @(negedge clk);
        checkOutput("na_ades",   {31'b0, ades_o}, 32'h0);
        checkOutput("na_memsel", {28'b0, mem_sel_o}, 32'hC);
        checkOutput("na_stall",  {31'b0, stall_request_o}, 32'h1);
        tick();
        bus(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("na_wdata", ram_wdata_o, 32'hCCDD_0000);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 32'h0);
`endif

        // Asynchronous reset in the middle of WAIT
        tick();
        applyStimulus(1'b1, 1'b0, 4'b1111, 32'h0000_8000, 32'h0);
        tick();
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        checkOutput("ar_req",   {31'b0, ram_req_o}, 32'h0);
        checkOutput("ar_stall", {31'b0, stall_request_o}, 32'h0);
        checkOutput("ar_rdata", ram_read_data_o, 32'h0);
        checkOutput("ar_addr",  ram_addr_o, 32'h0);
        checkOutput("ar_wstrb", {28'b0, ram_wstrb_o}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("ar_idle_req", {31'b0, ram_req_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
